// File: rtl/croc_obi_reg_bridge.sv
// Package with the OBI subordinate and regbus types, followed by the OBI-to-regbus bridge.
// The bridge handles one transfer at a time and turns a hung regbus target into an OBI error.
package croc_pkg;
    localparam int unsigned ObiIdWidth = 4;

    typedef struct packed {
        logic [31:0]           addr;
        logic                  we;
        logic [3:0]            be;
        logic [31:0]           wdata;
        logic [ObiIdWidth-1:0] aid;
        logic                  a_optional;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        sbr_obi_a_chan_t a;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0]           rdata;
        logic [ObiIdWidth-1:0] rid;
        logic                  err;
        logic                  r_optional;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module croc_obi_reg_bridge
    import croc_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  sbr_obi_req_t obi_req_i,
    output sbr_obi_rsp_t obi_rsp_o,
    output reg_req_t     reg_req_o,
    input  reg_rsp_t     reg_rsp_i,
    output logic         busy_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REG  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int unsigned CNT_W    = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam int unsigned LAST_INT = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = LAST_INT[CNT_W-1:0];

    logic [1:0]            r_state;
    logic [31:0]           r_addr;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic [ObiIdWidth-1:0] r_aid;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [CNT_W-1:0]      r_cnt;

    logic w_timeout;
    logic w_unused_optional;

    assign w_unused_optional = obi_req_i.a.a_optional;
    assign w_timeout = (TimeoutCycles != 0) && (r_cnt == CNT_LAST);
    assign busy_o    = (r_state != ST_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_aid   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (obi_req_i.req) begin
                        r_addr  <= obi_req_i.a.addr;
                        r_we    <= obi_req_i.a.we;
                        r_be    <= obi_req_i.a.be;
                        r_wdata <= obi_req_i.a.wdata;
                        r_aid   <= obi_req_i.a.aid;
                        r_cnt   <= '0;
                        r_state <= ST_REG;
                    end
                end
                ST_REG: begin
                    // A ready arriving on the timeout cycle still delivers the real result.
                    if (reg_rsp_i.ready) begin
                        r_rdata <= r_we ? 32'd0 : reg_rsp_i.rdata;
                        r_err   <= reg_rsp_i.error;
                        r_state <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        obi_rsp_o = '0;
        reg_req_o = '0;
        case (r_state)
            ST_IDLE: obi_rsp_o.gnt = obi_req_i.req;
            ST_REG: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.addr  = r_addr;
                reg_req_o.write = r_we;
                reg_req_o.wdata = r_wdata;
                reg_req_o.wstrb = r_be;
            end
            ST_RESP: begin
                obi_rsp_o.rvalid  = 1'b1;
                obi_rsp_o.r.rdata = r_rdata;
                obi_rsp_o.r.rid   = r_aid;
                obi_rsp_o.r.err   = r_err;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_croc_obi_reg_bridge.sv
// Bench for croc_obi_reg_bridge: directed scenarios plus random transfers, each response
// predicted from the transfer's wait count, direction and the timeout limit.
module tb_croc_obi_reg_bridge;
    import croc_pkg::*;

    localparam int unsigned T_MAIN = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    sbr_obi_req_t obi_req = '0;
    sbr_obi_rsp_t obi_rsp;
    reg_req_t     reg_req;
    reg_rsp_t     reg_rsp = '0;
    logic         busy;

    sbr_obi_req_t obi_req0 = '0;
    sbr_obi_rsp_t obi_rsp0;
    reg_req_t     reg_req0;
    reg_rsp_t     reg_rsp0 = '0;
    logic         busy0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    croc_obi_reg_bridge #(.TimeoutCycles(T_MAIN)) dut (
        .clk_i(clk), .rst_i(rst), .obi_req_i(obi_req), .obi_rsp_o(obi_rsp),
        .reg_req_o(reg_req), .reg_rsp_i(reg_rsp), .busy_o(busy)
    );

    croc_obi_reg_bridge #(.TimeoutCycles(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .obi_req_i(obi_req0), .obi_rsp_o(obi_rsp0),
        .reg_req_o(reg_req0), .reg_rsp_i(reg_rsp0), .busy_o(busy0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    // One OBI transfer; the target raises ready on valid cycle number waits+1.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [3:0] aid, input int waits,
                       input logic err_in, input logic [31:0] rd_in, input logic hold_req,
                       output int gnt_cyc);
        bit          timed;
        int          exp_valid;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          nvalid;
        bit          got;
        timed     = (waits >= int'(T_MAIN));
        exp_valid = timed ? int'(T_MAIN) : waits + 1;
        exp_rdata = timed ? 32'd0 : (we ? 32'd0 : rd_in);
        exp_err   = timed ? 1'b1 : err_in;

        @(posedge clk); #1;
        reg_rsp         = '0;
        obi_req.req     = 1'b1;
        obi_req.a.addr  = addr;
        obi_req.a.we    = we;
        obi_req.a.be    = be;
        obi_req.a.wdata = wdata;
        obi_req.a.aid   = aid;
        obi_req.a.a_optional = 1'($urandom);
        @(negedge clk);
        chk("gnt", obi_rsp.gnt, 1);
        chk("idle_rvalid", obi_rsp.rvalid, 0);
        chk("idle_valid", reg_req.valid, 0);
        gnt_cyc = cyc;

        nvalid = 0;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk); #1;
            if (!hold_req) obi_req.req = 1'b0;
            obi_req.a.addr  = $urandom;
            obi_req.a.wdata = $urandom;
            obi_req.a.we    = 1'($urandom);
            obi_req.a.be    = 4'($urandom);
            obi_req.a.aid   = 4'($urandom);
            reg_rsp.ready   = (k == waits);
            reg_rsp.error   = (k == waits) ? err_in : 1'b0;
            reg_rsp.rdata   = (k == waits) ? rd_in : $urandom;
            @(negedge clk);
            chk("no_gnt_busy", obi_rsp.gnt, 0);
            chk("busy", busy, (k <= exp_valid) ? 1 : 0);
            chk("progress", {63'd0, reg_req.valid | obi_rsp.rvalid}, 1);
            if (reg_req.valid) begin
                nvalid++;
                chk("rv_rvalid", obi_rsp.rvalid, 0);
                chk("reg_addr", reg_req.addr, addr);
                chk("reg_write", reg_req.write, we);
                chk("reg_wdata", reg_req.wdata, wdata);
                chk("reg_wstrb", reg_req.wstrb, be);
            end else if (obi_rsp.rvalid) begin
                got = 1;
                chk("latency", k, exp_valid);
                chk("rid", obi_rsp.r.rid, aid);
                chk("rdata", obi_rsp.r.rdata, exp_rdata);
                chk("err", obi_rsp.r.err, exp_err);
                chk("ropt", obi_rsp.r.r_optional, 0);
            end
        end
        chk("rvalid_seen", got, 1);
        chk("valid_cycles", nvalid, exp_valid);
        $display("txn we=%0d addr=%h aid=%0d waits=%0d -> valid_cycles=%0d timeout=%0d",
                 we, addr, aid, waits, nvalid, timed);
    endtask

    initial begin
        int g1, g2, cnt0;
        logic [3:0] aid_r;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_regreq", reg_req, 0);
        chk("rst_rvalid", obi_rsp.rvalid, 0);
        chk("rst_r", obi_rsp.r, 0);
        chk("rst_gnt", obi_rsp.gnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        txn(1, 32'h0300_2004, 32'hDEAD_BEEF, 4'hF, 4'd5, 0, 0, 32'hCAFE_0001, 0, g1);
        txn(0, 32'h0300_5000, 32'h0, 4'hF, 4'd2, 3, 0, 32'h1234_5678, 1, g1);
        txn(0, 32'h0300_6008, 32'h0, 4'h3, 4'd7, 1, 1, 32'hA5A5_5A5A, 0, g1);
        txn(0, 32'h0300_7000, 32'h0, 4'hF, 4'd9, 50, 0, 32'h1111_2222, 0, g1);
        txn(1, 32'h0300_7004, 32'h5555_AAAA, 4'hC, 4'd4, 7, 0, 32'h3333_4444, 0, g1);
        txn(0, 32'h0300_700C, 32'h0, 4'hF, 4'd11, 8, 1, 32'h7777_8888, 0, g1);

        // Back-to-back with req held
        txn(0, 32'h0300_1000, 32'h0, 4'hF, 4'd1, 0, 0, 32'h0BAD_F00D, 1, g1);
        txn(0, 32'h0300_1004, 32'h0, 4'hF, 4'd3, 0, 0, 32'h600D_CAFE, 0, g2);
        chk("b2b_gap", g2 - g1, 3);
        $display("b2b gnt gap=%0d", g2 - g1);

        // Reset in the second REG cycle
        @(posedge clk); #1;
        obi_req.req = 1'b1;
        obi_req.a.addr = 32'h0300_9000;
        obi_req.a.we = 1'b0;
        obi_req.a.aid = 4'd12;
        reg_rsp = '0;
        @(posedge clk); #1;
        obi_req.req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_valid_pre", reg_req.valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_valid", reg_req.valid, 0);
        chk("mid_rvalid", obi_rsp.rvalid, 0);
        chk("mid_busy", busy, 0);
        @(negedge clk);
        chk("mid_rvalid_hold", obi_rsp.rvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset mid-transaction applied");
        txn(0, 32'h0300_9004, 32'h0, 4'hF, 4'd6, 2, 0, 32'h4242_4242, 0, g1);

        // Random transfers
        for (int i = 0; i < 30; i++) begin
            aid_r = 4'($urandom);
            txn(1'($urandom), $urandom, $urandom, 4'($urandom), aid_r,
                $urandom_range(0, 10), 1'($urandom), $urandom,
                (i == 29) ? 1'b0 : 1'($urandom), g1);
        end

        // Timeout disabled: valid must persist
        @(posedge clk); #1;
        obi_req0.req = 1'b1;
        obi_req0.a.addr = 32'h0300_F000;
        obi_req0.a.aid = 4'd8;
        @(negedge clk);
        chk("t0_gnt", obi_rsp0.gnt, 1);
        @(posedge clk); #1;
        obi_req0.req = 1'b0;
        cnt0 = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (reg_req0.valid && !obi_rsp0.rvalid) cnt0++;
        end
        chk("t0_valid_cycles", cnt0, 1000);
        chk("t0_busy", busy0, 1);
        $display("timeout disabled: valid held %0d cycles", cnt0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
